led_bar_sequencer: RTL and testbench
====================================

Name: led_bar_sequencer

Overview:
- Parametrised next-generation LED bar-graph driver. Integrates the step prescaler, a bounded start/end position counter and the LED decoder in one block.
- Generalised in LED count and step rate.
- Adds bounce, hold and dot modes, synchronous load, and terminal-count pulse `check`.
- Sits between board switches/FSM control and the LED pins.

Parameters:
- N_LEDS, 16, number of LEDs driven; legal range 2..64.
- CW, $clog2(N_LEDS+1) (5 at default), width of position values 0..N_LEDS.
- DIV, 50_000_000, clk cycles per counter step; DIV>=1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  step enable; low freezes prescaler and count.
- load  in  1  synchronous restart from start position; one-cycle pulse or level.
- start_num  in  CW  first bound (unsigned).
- end_num  in  CW  second bound (unsigned).
- mode  in  2  00 up-wrap, 01 down-wrap, 10 bounce, 11 hold.
- dot_mode  in  1  0 thermometer bar, 1 single dot.
- count  out  CW  current position.
- dir  out  1  current direction, 1=up.
- check  out  1  one-cycle terminal pulse.
- led_out  out  N_LEDS  registered LED pattern.

Behaviour:
- Reset (rst=0, async): prescaler=0, count=0, dir=1, check=0, led_out=0.
- Bound clamping: each bound is clamped to N_LEDS. lo=min(clamped start_num, end_num); hi=max(...).
- Prescaler: counts 0..DIV-1 while en=1. tick=en && prescaler==DIV-1. Prescaler returns to 0 after tick. DIV=1 gives tick every enabled cycle.
- Load priority: load > tick. On load: prescaler=0, check=0.
  - mode 01: count=hi, dir=0.
  - Otherwise: count=lo, dir=1.
- On tick edge, registered with count update:
  - mode 00: count<hi -> count+1. count==hi -> count=lo. check=1 on the edge where count becomes hi.
  - mode 01: count>lo -> count-1. count==lo -> count=hi. check=1 on the edge where count becomes lo.
  - mode 10:
    - dir=1: count+1. Upon reaching hi, set dir=0 on the same edge and pulse check.
    - dir=0: mirror of dir=1, turning at lo.
    - Never exceeds bounds.
  - mode 11: count, dir unchanged; check=0; prescaler keeps running.
- Degenerate lo==hi: count held at lo; check=1 on every tick in modes 00/01/10.
- Out of range (count<lo or count>hi after a bound change without load): next tick snaps count to the load value for the current mode, with no check. Between ticks, count is not altered.
- Mode change mid-run: takes effect at next tick from the current count. In mode 10, dir keeps its value.
- check is high exactly one clk cycle and is 0 on all non-tick cycles.
- led_out is registered, one cycle after count.
  - Thermometer: bit i = (i < count).
  - Dot: only bit count-1 set; count=0 -> all zero.
- rst asserted mid-step: immediate async clear. First tick after release occurs DIV enabled cycles later.

Test Plan (DIV=4, N_LEDS=16 unless noted):
1. Reset then load, mode 00, start 3, end 6, en=1 -> count 3,4,5,6,3,4 every 4 cycles. check high only on the cycle count becomes 6. led_out=0x003F one cycle after count=6.
2. mode 01, start 6, end 3, load -> count 6,5,4,3,6. check on reaching 3. Swapped bounds give identical sequence.
3. mode 10, bounds 0..3 -> count 0,1,2,3,2,1,0,1. dir falls on the 3 edge, rises on the 0 edge. check pulses at 3 and at 0.
4. dot_mode=1, count=5 -> led_out=0x0010. count=0 -> 0x0000. end_num=31 clamps to 16: thermometer at 16 -> 0xFFFF, no bit beyond N_LEDS-1.
5. en=0 for 10 cycles mid-step, then en=1 -> count unchanged and no tick while low. Remaining prescaler cycles preserved. mode 11 -> count frozen, check never asserts.
6. rst pulsed low between clock edges during mode 10 at count=2 -> count, led_out, check, dir return to reset values immediately. load and tick coincident -> load value wins, check=0. N_LEDS=8, DIV=1 build -> count steps every cycle, CW=4.

Source files
------------

// File: rtl/led_bar_sequencer.sv
// -----------------------------------------------------------------------------
// led_bar_sequencer
//   LED bar-graph driver. A prescaler produces a step tick every DIV enabled
//   clocks. A position counter moves between two clamped bounds in up-wrap,
//   down-wrap, bounce or hold mode. The position is decoded into a registered
//   thermometer bar or a single dot.
//
// Ports
//   clk        system clock
//   rst        asynchronous reset, active low
//   en         step enable; low freezes both the prescaler and the position
//   load       synchronous restart from the start position; wins over a tick
//   start_num  first bound, clamped to N_LEDS
//   end_num    second bound, clamped to N_LEDS
//   mode       00 up-wrap, 01 down-wrap, 10 bounce, 11 hold
//   dot_mode   0 thermometer bar, 1 single dot
//   count      current position, 0..N_LEDS
//   dir        current direction, 1 = up
//   check      one-cycle pulse on the tick that reaches the terminal bound
//   led_out    LED pattern, registered one cycle behind count
// -----------------------------------------------------------------------------
module led_bar_sequencer #(
  parameter int N_LEDS = 16,
  parameter int CW     = $clog2(N_LEDS + 1),
  parameter int DIV    = 50_000_000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              load,
  input  logic [CW-1:0]     start_num,
  input  logic [CW-1:0]     end_num,
  input  logic [1:0]        mode,
  input  logic              dot_mode,
  output logic [CW-1:0]     count,
  output logic              dir,
  output logic              check,
  output logic [N_LEDS-1:0] led_out
);

  localparam int            PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] N_MAX    = CW'(N_LEDS);

  localparam logic [1:0] MODE_UP     = 2'b00;
  localparam logic [1:0] MODE_DOWN   = 2'b01;
  localparam logic [1:0] MODE_BOUNCE = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  logic [PW-1:0]     presc_q, presc_d;
  logic [CW-1:0]     count_q, count_d;
  logic              dir_q, dir_d;
  logic              check_q, check_d;
  logic [N_LEDS-1:0] led_q, led_d;

  logic [CW-1:0] start_c, end_c, lo, hi;
  logic [CW-1:0] count_inc, count_dec;
  logic [CW-1:0] load_count;
  logic          load_dir;
  logic          tick;

  // Bound clamping and ordering: the counter always runs on lo <= hi.
  always_comb begin
    start_c    = (start_num > N_MAX) ? N_MAX : start_num;
    end_c      = (end_num   > N_MAX) ? N_MAX : end_num;
    lo         = (start_c < end_c) ? start_c : end_c;
    hi         = (start_c < end_c) ? end_c   : start_c;
    count_inc  = count_q + 1'b1;
    count_dec  = count_q - 1'b1;
    tick       = en && (presc_q == PRE_LAST);
    // Restart point: down-wrap starts at the top going down, all others at
    // the bottom going up. Also the snap target for an out-of-range count.
    load_count = (mode == MODE_DOWN) ? hi : lo;
    load_dir   = (mode != MODE_DOWN);
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first so that no path
    // leaves it unassigned, which would infer a latch.
    presc_d = presc_q;
    count_d = count_q;
    dir_d   = dir_q;
    check_d = 1'b0;

    if (load) begin
      presc_d = '0;
      count_d = load_count;
      dir_d   = load_dir;
    end else if (en) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (tick && (mode != MODE_HOLD)) begin
        if ((count_q < lo) || (count_q > hi)) begin
          // Bounds moved under the counter without a load: restart quietly.
          count_d = load_count;
          dir_d   = load_dir;
        end else if (lo == hi) begin
          count_d = lo;
          check_d = 1'b1;
        end else begin
          case (mode)
            MODE_UP: begin
              if (count_q == hi) begin
                count_d = lo;
              end else begin
                count_d = count_inc;
                check_d = (count_inc == hi);
              end
            end
            MODE_DOWN: begin
              if (count_q == lo) begin
                count_d = hi;
              end else begin
                count_d = count_dec;
                check_d = (count_dec == lo);
              end
            end
            MODE_BOUNCE: begin
              // Direction flips on the same edge that lands on a bound, so
              // the next step already heads back inside the range.
              if (dir_q) begin
                if (count_q == hi) begin
                  count_d = count_dec;
                  dir_d   = 1'b0;
                end else begin
                  count_d = count_inc;
                  if (count_inc == hi) begin
                    dir_d   = 1'b0;
                    check_d = 1'b1;
                  end
                end
              end else begin
                if (count_q == lo) begin
                  count_d = count_inc;
                  dir_d   = 1'b1;
                end else begin
                  count_d = count_dec;
                  if (count_dec == lo) begin
                    dir_d   = 1'b1;
                    check_d = 1'b1;
                  end
                end
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // LED decode from the registered position; the result is registered again.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (dot_mode) begin
        led_d[i] = (count_q != '0) && (CW'(i) == count_dec);
      end else begin
        led_d[i] = (CW'(i) < count_q);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b1;
      check_q <= 1'b0;
      led_q   <= '0;
    end else begin
      presc_q <= presc_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      check_q <= check_d;
      led_q   <= led_d;
    end
  end

  assign count   = count_q;
  assign dir     = dir_q;
  assign check   = check_q;
  assign led_out = led_q;

endmodule

// File: tb/tb_led_bar_sequencer.sv
// -----------------------------------------------------------------------------
// tb_led_bar_sequencer
//   Scoreboard bench. The stimulus process drives inputs just after each
//   rising edge and queues the hand-derived state the DUT must show for that
//   cycle; a monitor pops and compares on every falling edge.
//   dut  : N_LEDS=16, DIV=4
//   dut2 : N_LEDS=8,  DIV=1
// -----------------------------------------------------------------------------
module tb_led_bar_sequencer;

  typedef struct {
    int          c;
    logic        d;
    logic        k;
    logic [63:0] led;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en, load, dot_mode;
  logic [4:0]  start_num, end_num;
  logic [1:0]  mode;
  logic [4:0]  count;
  logic        dir, check;
  logic [15:0] led_out;

  logic        en2, load2, dot2;
  logic [3:0]  start2, end2;
  logic [1:0]  mode2;
  logic [3:0]  count2;
  logic        dir2, check2;
  logic [7:0]  led2;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t ea, eb;
  int   prev_a, prev_b;
  int   n_cmp, n_fail;

  led_bar_sequencer #(.N_LEDS(16), .DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .start_num(start_num), .end_num(end_num), .mode(mode), .dot_mode(dot_mode),
    .count(count), .dir(dir), .check(check), .led_out(led_out)
  );

  led_bar_sequencer #(.N_LEDS(8), .DIV(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .load(load2),
    .start_num(start2), .end_num(end2), .mode(mode2), .dot_mode(dot2),
    .count(count2), .dir(dir2), .check(check2), .led_out(led2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected LED pattern for a position c.
  function automatic logic [63:0] pat(input int c, input logic dm);
    logic [63:0] one;
    one = 64'd1;
    if (dm) return (c == 0) ? 64'd0 : (one << (c - 1));
    return (one << c) - one;
  endfunction

  // Monitor: compares whatever the stimulus expected for this cycle.
  always @(negedge clk) begin
    if (q_a.size() > 0) begin
      ea = q_a.pop_front();
      check_val("count", 64'(count), 64'(ea.c));
      check_val("dir", 64'(dir), 64'(ea.d));
      check_val("check", 64'(check), 64'(ea.k));
      check_val("led_out", 64'(led_out), ea.led);
    end
    if (q_b.size() > 0) begin
      eb = q_b.pop_front();
      check_val("n8_count", 64'(count2), 64'(eb.c));
      check_val("n8_dir", 64'(dir2), 64'(eb.d));
      check_val("n8_check", 64'(check2), 64'(eb.k));
      check_val("n8_led_out", 64'(led2), eb.led);
    end
  end

  // The LED register shows the decode of the position held before this edge.
  task automatic push_a(input int c, input logic d, input logic k);
    exp_t e;
    e.c   = c;
    e.d   = d;
    e.k   = k;
    e.led = rst ? pat(prev_a, dot_mode) : 64'd0;
    prev_a = rst ? c : 0;
    q_a.push_back(e);
  endtask

  task automatic push_b(input int c, input logic d, input logic k);
    exp_t e;
    e.c   = c;
    e.d   = d;
    e.k   = k;
    e.led = pat(prev_b, dot2);
    prev_b = c;
    q_b.push_back(e);
  endtask

  // n cycles holding position c; check expected only on the first of them.
  task automatic hold(input int c, input logic d, input logic k, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      push_a(c, d, (i == 0) ? k : 1'b0);
    end
  endtask

  task automatic setup(input logic [1:0] m, input int s, input int e);
    mode      = m;
    start_num = 5'(s);
    end_num   = 5'(e);
  endtask

  // Load pulse followed by the rest of the first DIV-cycle step.
  task automatic do_load(input int c, input logic d);
    load = 1'b1;
    hold(c, d, 1'b0, 1);
    load = 1'b0;
    hold(c, d, 1'b0, 3);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_fail = 0; prev_a = 0; prev_b = 0;
    rst = 1'b0; en = 1'b0; load = 1'b0; dot_mode = 1'b0;
    setup(2'b00, 0, 0);
    en2 = 1'b0; load2 = 1'b0; dot2 = 1'b0; mode2 = 2'b00; start2 = 4'd0; end2 = 4'd0;

    // Reset state.
    hold(0, 1'b1, 1'b0, 2);
    rst = 1'b1;

    // 1: up-wrap 3..6.
    en = 1'b1;
    setup(2'b00, 3, 6);
    do_load(3, 1'b1);
    hold(4, 1'b1, 1'b0, 4);
    hold(5, 1'b1, 1'b0, 4);
    hold(6, 1'b1, 1'b1, 4);
    hold(3, 1'b1, 1'b0, 4);
    hold(4, 1'b1, 1'b0, 4);

    // 2: down-wrap, then the same with swapped bounds.
    for (int p = 0; p < 2; p++) begin
      setup(2'b01, (p == 0) ? 6 : 3, (p == 0) ? 3 : 6);
      do_load(6, 1'b0);
      hold(5, 1'b0, 1'b0, 4);
      hold(4, 1'b0, 1'b0, 4);
      hold(3, 1'b0, 1'b1, 4);
      hold(6, 1'b0, 1'b0, 4);
    end

    // 3: bounce 0..3.
    setup(2'b10, 0, 3);
    do_load(0, 1'b1);
    hold(1, 1'b1, 1'b0, 4);
    hold(2, 1'b1, 1'b0, 4);
    hold(3, 1'b0, 1'b1, 4);
    hold(2, 1'b0, 1'b0, 4);
    hold(1, 1'b0, 1'b0, 4);
    hold(0, 1'b1, 1'b1, 4);
    hold(1, 1'b1, 1'b0, 4);

    // 4: dot mode 0..5, then thermometer with end clamped from 31 to 16.
    dot_mode = 1'b1;
    setup(2'b00, 0, 5);
    do_load(0, 1'b1);
    for (int c = 1; c <= 4; c++) hold(c, 1'b1, 1'b0, 4);
    hold(5, 1'b1, 1'b1, 4);
    hold(0, 1'b1, 1'b0, 4);
    dot_mode = 1'b0;
    setup(2'b00, 14, 31);
    do_load(14, 1'b1);
    hold(15, 1'b1, 1'b0, 4);
    hold(16, 1'b1, 1'b1, 4);
    hold(14, 1'b1, 1'b0, 2);

    // 5: enable low mid-step keeps the prescaler phase; hold mode freezes.
    setup(2'b00, 3, 6);
    load = 1'b1;
    hold(3, 1'b1, 1'b0, 1);
    load = 1'b0;
    hold(3, 1'b1, 1'b0, 2);
    en = 1'b0;
    hold(3, 1'b1, 1'b0, 10);
    en = 1'b1;
    hold(3, 1'b1, 1'b0, 1);
    hold(4, 1'b1, 1'b0, 4);
    mode = 2'b11;
    hold(4, 1'b1, 1'b0, 12);

    // 6a: asynchronous reset between edges in bounce at count 2.
    setup(2'b10, 0, 3);
    do_load(0, 1'b1);
    hold(1, 1'b1, 1'b0, 4);
    hold(2, 1'b1, 1'b0, 2);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_val("async_rst_count", 64'(count), 64'd0);
    check_val("async_rst_dir", 64'(dir), 64'd1);
    check_val("async_rst_check", 64'(check), 64'd0);
    check_val("async_rst_led", 64'(led_out), 64'd0);
    hold(0, 1'b1, 1'b0, 2);
    rst = 1'b1;
    // First tick lands DIV enabled cycles after release.
    hold(0, 1'b1, 1'b0, 3);
    hold(1, 1'b1, 1'b0, 4);

    // 6b: load coincident with a tick; a tick would have given 2.
    setup(2'b00, 1, 9);
    load = 1'b1;
    hold(1, 1'b1, 1'b0, 1);
    load = 1'b0;
    hold(1, 1'b1, 1'b0, 1);
    // Bounds move above the count: unchanged until the tick, then snap, no check.
    setup(2'b00, 10, 12);
    hold(1, 1'b1, 1'b0, 2);
    hold(10, 1'b1, 1'b0, 4);
    hold(11, 1'b1, 1'b0, 4);
    hold(12, 1'b1, 1'b1, 4);

    // Degenerate lo == hi: held, check on every tick.
    setup(2'b00, 7, 7);
    do_load(7, 1'b1);
    hold(7, 1'b1, 1'b1, 4);
    hold(7, 1'b1, 1'b1, 4);
    en = 1'b0;

    // 6c: N_LEDS=8, DIV=1 steps every enabled cycle, 0..8 then wrap.
    en2 = 1'b1; mode2 = 2'b00; start2 = 4'd0; end2 = 4'd8; load2 = 1'b1;
    @(posedge clk);
    #1;
    push_b(0, 1'b1, 1'b0);
    load2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      push_b((c <= 8) ? c : c - 9, 1'b1, c == 8);
    end
    en2 = 1'b0;

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 20 && (q_a.size() + q_b.size()) > 0; i++) @(posedge clk);
    #1;
    check_val("scoreboard_drained", 64'(q_a.size() + q_b.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
